// File: rtl/apb_req_pkg.sv
// Shared types for the APB test requester.
//   state_e : requester FSM states (idle, setup, access, response)
//   rsp_t   : captured response (read data, error flag, timeout flag)
// rdata is sized to MaxDataWidth so one struct serves every DATA_WIDTH up to that limit.
package apb_req_pkg;

  localparam int unsigned MaxDataWidth = 64;
  localparam int unsigned StatWidth    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  typedef struct packed {
    logic [MaxDataWidth-1:0] rdata;
    logic                    err;
    logic                    timeout;
  } rsp_t;

  // Width needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/apb_test_requester_if.sv
// APB bus bundle between one requester and one completer.
//   requester modport : drives psel/penable/pwrite/paddr/pwdata, samples pready/prdata/pslverr
//   completer modport : the mirror image
interface apb_test_requester_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport requester (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport completer (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : increment request
//   count : current count
module apb_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/apb_test_requester.sv
// APB test requester: turns one command at a time into an APB transfer and returns a response.
//   pclk, preset_n       : clock and asynchronous active-low reset
//   apb                  : APB bus, requester side
//   cmd_valid/cmd_ready  : command handshake; cmd_write, cmd_addr, cmd_wdata carry the command
//   rsp_valid/rsp_ready  : response handshake; rsp_rdata, rsp_err, rsp_timeout carry the result
// Optional build macro APB_REQ_STATS_EN adds saturating counters stat_xfers, stat_errs and
// stat_timeouts, each bumped when a transfer enters the response state.
// DATA_WIDTH must not exceed apb_req_pkg::MaxDataWidth.
module apb_test_requester
  import apb_req_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  apb_test_requester_if.requester apb,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout
`ifdef APB_REQ_STATS_EN
  ,
  output logic [StatWidth-1:0]  stat_xfers,
  output logic [StatWidth-1:0]  stat_errs,
  output logic [StatWidth-1:0]  stat_timeouts
`endif
);

  localparam int unsigned      CntWidth = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  rsp_t                  rsp_q, rsp_d;

  logic cmd_accept;
  logic pready_hit;
  logic tmo_hit;

  assign cmd_accept = cmd_valid && cmd_ready;
  assign pready_hit = (state_q == StAccess) && apb.pready;
  // pready takes priority over the terminal count in the same cycle.
  assign tmo_hit    = (state_q == StAccess) && !apb.pready && (cnt_q == CntLast);

  // State register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cmd_accept) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (pready_hit || tmo_hit) state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from state. cmd_ready is gated by reset so it reads 0 while held in reset.
  always_comb begin
    cmd_ready   = (state_q == StIdle) && preset_n;
    apb.psel    = (state_q == StSetup) || (state_q == StAccess);
    apb.penable = (state_q == StAccess);
    rsp_valid   = (state_q == StResp);
  end

  // Response captured as ACCESS ends; it is only written there, so it is stable throughout RESP.
  always_comb begin
    rsp_d = rsp_q;
    if (pready_hit) begin
      rsp_d.rdata   = write_q ? '0 : MaxDataWidth'(apb.prdata);
      rsp_d.err     = apb.pslverr;
      rsp_d.timeout = 1'b0;
    end else if (tmo_hit) begin
      rsp_d.rdata   = '0;
      rsp_d.err     = 1'b1;
      rsp_d.timeout = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      if (cmd_accept) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        cnt_q   <= '0;
      end else if ((state_q == StAccess) && !apb.pready && (cnt_q != CntMax)) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
      rsp_q <= rsp_d;
    end
  end

  assign apb.pwrite = write_q;
  assign apb.paddr  = addr_q;
  assign apb.pwdata = wdata_q;

  assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

  // Upper rdata bits beyond DATA_WIDTH are always zero.
  logic unused_rsp_rdata;
  assign unused_rsp_rdata = ^rsp_q.rdata;

`ifdef APB_REQ_STATS_EN
  apb_sat_counter #(
    .WIDTH (StatWidth)
  ) u_stat_xfers (
    .clk   (pclk),
    .rst_n (preset_n),
    .inc   (pready_hit || tmo_hit),
    .count (stat_xfers)
  );

  apb_sat_counter #(
    .WIDTH (StatWidth)
  ) u_stat_errs (
    .clk   (pclk),
    .rst_n (preset_n),
    .inc   ((pready_hit && apb.pslverr) || tmo_hit),
    .count (stat_errs)
  );

  apb_sat_counter #(
    .WIDTH (StatWidth)
  ) u_stat_timeouts (
    .clk   (pclk),
    .rst_n (preset_n),
    .inc   (tmo_hit),
    .count (stat_timeouts)
  );
`endif

endmodule

// File: tb/tb_apb_test_requester.sv
// Bench for apb_test_requester: a behavioural APB completer with programmable wait states and
// error response, plus a transaction-level reference model (memory map, expected response,
// expected bus occupancy and latency, expected statistics).
module tb_apb_test_requester;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic          pclk = 1'b0;
  logic          preset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
`ifdef APB_REQ_STATS_EN
  logic [15:0]   stat_xfers;
  logic [15:0]   stat_errs;
  logic [15:0]   stat_timeouts;
`endif

  always #5 pclk = ~pclk;

  apb_test_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_bus ();

  apb_test_requester #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .pclk          (pclk),
    .preset_n      (preset_n),
    .apb           (apb_bus),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .rsp_timeout   (rsp_timeout)
`ifdef APB_REQ_STATS_EN
    ,
    .stat_xfers    (stat_xfers),
    .stat_errs     (stat_errs),
    .stat_timeouts (stat_timeouts)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Completer configuration for the next transfer.
  int cfg_waits = 0;
  bit cfg_err   = 1'b0;
  int wait_left = 0;
  bit [31:0] cmem [bit [31:0]];

  // Reference model state.
  bit [31:0] ref_mem [bit [31:0]];
  int exp_xfers = 0;
  int exp_errs  = 0;
  int exp_tmos  = 0;

  // Behavioural completer: cfg_waits cycles of pready=0 in ACCESS, then pready=1.
  // Writes land in its memory only when no error is returned.
  initial begin
    apb_bus.pready  = 1'b0;
    apb_bus.prdata  = '0;
    apb_bus.pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if (apb_bus.psel && apb_bus.penable) begin
        if (wait_left == 0) begin
          apb_bus.pready  = 1'b1;
          apb_bus.pslverr = cfg_err;
          if (apb_bus.pwrite) begin
            apb_bus.prdata = $urandom;
            if (!cfg_err) cmem[apb_bus.paddr] = apb_bus.pwdata;
          end else begin
            apb_bus.prdata = cmem.exists(apb_bus.paddr) ? cmem[apb_bus.paddr] : 32'h0;
          end
        end else begin
          wait_left--;
          apb_bus.pready  = 1'b0;
          apb_bus.pslverr = 1'b0;
          apb_bus.prdata  = $urandom;
        end
      end else begin
        apb_bus.pready  = 1'b0;
        apb_bus.pslverr = 1'b0;
        wait_left       = cfg_waits;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one command (called at a negedge) and checks the whole transfer against the model.
  // hold = cycles rsp_ready stays low; offer_next keeps cmd_valid high during that hold.
  task automatic do_txn(input bit wr, input bit [31:0] addr, input bit [31:0] wdata,
                        input int waits, input bit slverr, input int hold,
                        input bit offer_next, output int acc_wait);
    bit        exp_tmo, exp_err, stable_ok, busy_ok;
    bit [31:0] exp_rd;
    int        exp_psel, psel_cnt, cyc;

    exp_tmo  = (waits >= int'(TMO));
    exp_err  = exp_tmo ? 1'b1 : slverr;
    exp_rd   = (!wr && !exp_tmo) ? (ref_mem.exists(addr) ? ref_mem[addr] : 32'h0) : 32'h0;
    exp_psel = 1 + (exp_tmo ? int'(TMO) : waits + 1);
    if (wr && !exp_tmo && !slverr) ref_mem[addr] = wdata;
    exp_xfers++;
    if (exp_err) exp_errs++;
    if (exp_tmo) exp_tmos++;

    cfg_waits = waits;
    cfg_err   = slverr;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    acc_wait  = 0;
    while (cmd_ready !== 1'b1 && acc_wait < 50) begin
      @(negedge pclk);
      acc_wait++;
    end
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, acc_wait);
      n_fail++;
      cmd_valid = 1'b0;
      return;
    end
    @(negedge pclk);
    cmd_valid = 1'b0;

    n_tests++;
    if (apb_bus.psel !== 1'b1 || apb_bus.penable !== 1'b0) begin
      $display("FAIL setup: psel=%b penable=%b one cycle after accept, required 1/0",
               apb_bus.psel, apb_bus.penable);
      n_fail++;
    end

    psel_cnt  = 0;
    stable_ok = 1'b1;
    busy_ok   = 1'b1;
    cyc       = 2;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      if (cmd_ready !== 1'b0) busy_ok = 1'b0;
      if (apb_bus.psel === 1'b1) begin
        psel_cnt++;
        if (apb_bus.paddr !== addr || apb_bus.pwrite !== wr || apb_bus.pwdata !== wdata)
          stable_ok = 1'b0;
      end
      @(negedge pclk);
      cyc++;
    end

    n_tests++;
    if (rsp_valid !== 1'b1) begin
      $display("FAIL rsp_valid: not seen within %0d cycles", cyc);
      n_fail++;
      rsp_ready = 1'b1;
      @(negedge pclk);
      rsp_ready = 1'b0;
      return;
    end
    n_tests++;
    if (psel_cnt != exp_psel) begin
      $display("FAIL psel_cycles: got %0d, required %0d", psel_cnt, exp_psel);
      n_fail++;
    end
    n_tests++;
    if (cyc != exp_psel + 2) begin
      $display("FAIL latency: rsp_valid in cycle %0d, required %0d", cyc, exp_psel + 2);
      n_fail++;
    end
    n_tests++;
    if (!stable_ok || !busy_ok) begin
      $display("FAIL bus_stable: addr/data/dir stable=%b cmd_ready low=%b, required 1/1",
               stable_ok, busy_ok);
      n_fail++;
    end
    n_tests++;
    if (rsp_rdata !== exp_rd || rsp_err !== exp_err || rsp_timeout !== exp_tmo) begin
      $display("FAIL response: rdata=%h err=%b timeout=%b, required %h/%b/%b",
               rsp_rdata, rsp_err, rsp_timeout, exp_rd, exp_err, exp_tmo);
      n_fail++;
    end

    if (offer_next) cmd_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge pclk);
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== exp_err ||
          rsp_timeout !== exp_tmo || cmd_ready !== 1'b0) begin
        $display("FAIL rsp_hold: valid=%b rdata=%h err=%b tmo=%b cmd_ready=%b, required 1/%h/%b/%b/0",
                 rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, exp_rd, exp_err, exp_tmo);
        n_fail++;
      end
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    #12;
    n_tests++;
    if (apb_bus.psel !== 1'b0 || apb_bus.penable !== 1'b0 || apb_bus.pwrite !== 1'b0 ||
        apb_bus.paddr !== '0 || apb_bus.pwdata !== '0 || rsp_valid !== 1'b0 ||
        rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== '0) begin
      $display("FAIL reset_outputs: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b err=%b tmo=%b rd=%h, required all 0",
               apb_bus.psel, apb_bus.penable, apb_bus.pwrite, apb_bus.paddr, apb_bus.pwdata,
               rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
      n_fail++;
    end
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      $display("FAIL reset_cmd_ready: got %b in reset, required 0", cmd_ready);
      n_fail++;
    end
    @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL release_cmd_ready: got %b after release, required 1", cmd_ready);
      n_fail++;
    end
  endtask

  task automatic test_write_read();
    int w;
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 0, 1'b0, w);
    do_txn(1'b0, 32'h10, $urandom, 0, 1'b0, 2, 1'b0, w);
  endtask

  task automatic test_wait_err();
    int w;
    do_txn(1'b0, 32'h20, $urandom, 3, 1'b1, 1, 1'b0, w);
    do_txn(1'b1, 32'h20, 32'h1234_5678, 2, 1'b1, 0, 1'b0, w);
  endtask

  task automatic test_timeout();
    int w;
    do_txn(1'b0, 32'h10, $urandom, int'(TMO), 1'b0, 1, 1'b0, w);
    do_txn(1'b1, 32'h10, 32'hBAD0BAD0, int'(TMO) + 20, 1'b0, 0, 1'b0, w);
    // Terminal count and pready coincide: pready wins.
    do_txn(1'b0, 32'h10, $urandom, int'(TMO) - 1, 1'b0, 0, 1'b0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    do_txn(1'b1, 32'h30, 32'hA5A5_0001, 0, 1'b0, 10, 1'b1, w);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL b2b_ready: cmd_ready=%b the cycle after rsp_ready, required 1", cmd_ready);
      n_fail++;
    end
    do_txn(1'b0, 32'h30, $urandom, 1, 1'b0, 0, 1'b0, w);
    n_tests++;
    if (w != 0) begin
      $display("FAIL b2b_accept: waited %0d cycles, required 0", w);
      n_fail++;
    end
  endtask

  task automatic test_random();
    int        w, waits;
    bit [31:0] addr;
    for (int i = 0; i < 24; i++) begin
      addr = 32'h10 * (($urandom % 4) + 1);
      case ($urandom % 6)
        0:       waits = int'(TMO) - 1;
        1:       waits = int'(TMO) + int'($urandom % 3);
        default: waits = int'($urandom_range(0, 3));
      endcase
      do_txn(1'($urandom % 2), addr, $urandom, waits, (($urandom % 4) == 0),
             int'($urandom_range(0, 3)), 1'b0, w);
    end
`ifdef APB_REQ_STATS_EN
    n_tests++;
    if (int'(stat_xfers) != exp_xfers || int'(stat_errs) != exp_errs ||
        int'(stat_timeouts) != exp_tmos) begin
      $display("FAIL stats: xfers=%0d errs=%0d tmos=%0d, required %0d/%0d/%0d",
               stat_xfers, stat_errs, stat_timeouts, exp_xfers, exp_errs, exp_tmos);
      n_fail++;
    end
`endif
  endtask

  task automatic test_reset_mid_access();
    int cnt;
    int w;
    @(negedge pclk);
    cfg_waits = 1000;
    cfg_err   = 1'b0;
    cmd_write = 1'b1;
    cmd_addr  = 32'h10;
    cmd_wdata = 32'h0BAD_F00D;
    cmd_valid = 1'b1;
    cnt = 0;
    while (cmd_ready !== 1'b1 && cnt < 20) begin
      @(negedge pclk);
      cnt++;
    end
    @(negedge pclk);
    cmd_valid = 1'b0;
    cnt = 0;
    while (apb_bus.penable !== 1'b1 && cnt < 20) begin
      @(negedge pclk);
      cnt++;
    end
    n_tests++;
    if (apb_bus.penable !== 1'b1) begin
      $display("FAIL mid_reset_access: penable=%b, required 1 before reset", apb_bus.penable);
      n_fail++;
    end
    @(negedge pclk);
    #2;
    preset_n = 1'b0;
    #1;
    n_tests++;
    if (apb_bus.psel !== 1'b0 || apb_bus.penable !== 1'b0 || rsp_valid !== 1'b0 ||
        cmd_ready !== 1'b0 || apb_bus.paddr !== '0) begin
      $display("FAIL mid_reset: psel=%b pen=%b rv=%b cmd_ready=%b paddr=%h, required 0/0/0/0/0",
               apb_bus.psel, apb_bus.penable, rsp_valid, cmd_ready, apb_bus.paddr);
      n_fail++;
    end
`ifdef APB_REQ_STATS_EN
    n_tests++;
    if (stat_xfers !== 16'h0) begin
      $display("FAIL mid_reset_stats: stat_xfers=%0d, required 0", stat_xfers);
      n_fail++;
    end
`endif
    exp_xfers = 0;
    exp_errs  = 0;
    exp_tmos  = 0;
    @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    // The aborted write never completed, so the earlier value must survive.
    do_txn(1'b0, 32'h10, $urandom, 0, 1'b0, 0, 1'b0, w);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_err();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_test_requester.md
APB_TEST_REQUESTER -- requirements
Module: apb_test_requester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum ACCESS-phase cycles before abort; legal range 1..65535.
REQ-004 SHALL have port pclk  input  1: sole clock; the APB bus is clocked by the same clock.
REQ-005 SHALL have port preset_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_valid  input  1: command offered.
REQ-007 SHALL have port cmd_ready  output  1: command accepted when both valid and ready are high.
REQ-008 SHALL have port cmd_write  input  1: 1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr  input  ADDR_WIDTH: target address.
REQ-010 SHALL have port cmd_wdata  input  DATA_WIDTH: write data.
REQ-011 SHALL have port rsp_valid  output  1: response available.
REQ-012 SHALL have port rsp_ready  input  1: response consumed when both valid and ready are high.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH: read data; 0 for writes and timeouts.
REQ-014 SHALL have port rsp_err  output  1: pslverr was sampled, or a timeout occurred.
REQ-015 SHALL have port rsp_timeout  output  1: transaction aborted by timeout.
REQ-016 SHALL have port apb  interface  APB.requester: drives psel, penable, pwrite, paddr and pwdata; samples pready, prdata and pslverr.

Function
REQ-017 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
REQ-018 In IDLE, cmd_ready SHALL be 1; on acceptance, SHALL register write, addr and wdata and enter SETUP on the next cycle.
REQ-019 In SETUP, SHALL drive psel=1 and penable=0 with the registered address, data and direction, then enter ACCESS unconditionally.
REQ-020 In ACCESS, SHALL drive psel=1 and penable=1; when pready=1, SHALL capture prdata (reads only) and pslverr, deassert psel and penable on the next cycle, and enter RESP.
REQ-021 In ACCESS, SHALL count cycles with pready=0; on reaching TIMEOUT_CYCLES, SHALL deassert psel and penable and enter RESP with rsp_timeout=1, rsp_err=1 and rsp_rdata=0.
REQ-022 In RESP, SHALL hold rsp_valid=1 and all response fields stable until rsp_ready=1, then return to IDLE.
REQ-023 Minimum latency SHALL be as follows:
- cmd accept to psel rising: 1 cycle;
- pready=1 with a zero-wait completer: SETUP, then ACCESS, then rsp_valid the cycle after pready;
- 4 cycles from cmd accept to rsp_valid.
REQ-024 cmd_ready SHALL be 0 in every state except IDLE; there is one transaction in flight, with no queueing.
REQ-025 When pready=1 and the timeout terminal count occur in the same cycle, pready SHALL win and no timeout SHALL be reported.
REQ-026 paddr, pwdata and pwrite SHALL remain stable from SETUP through the final ACCESS cycle.
REQ-027 The timeout counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits wide, cleared on entry to SETUP, and SHALL never wrap.

Reset
REQ-028 Asserting preset_n low SHALL asynchronously force the following, regardless of state, including mid-ACCESS:
- FSM to IDLE;
- psel, penable, pwrite, rsp_valid, rsp_err and rsp_timeout to 0;
- paddr, pwdata and rsp_rdata to 0;
- cmd_ready to 0 while in reset, and to 1 on the first cycle after release.

Configuration
REQ-029 When APB_REQ_STATS_EN is defined, SHALL add three 16-bit saturating output counters, stat_xfers, stat_errs and stat_timeouts, each incremented on entry to RESP for the matching condition, reset to 0, and holding at 0xFFFF.
REQ-030 When APB_REQ_STATS_EN is undefined, the counter ports and their logic SHALL be absent.

Structure
REQ-031 The package apb_req_pkg SHALL hold the FSM state enum (IDLE, SETUP, ACCESS, RESP) and the response struct (rdata, err, timeout).
REQ-032 The counters SHALL be instances of the sub-module apb_sat_counter (parameterised width, inc input, asynchronous active-low reset).

Verification
REQ-033 Write addr 0x10, data 0xDEADBEEF to a zero-wait completer -> one SETUP and one ACCESS cycle, then rsp_valid with rsp_err=0 and rsp_rdata=0.
REQ-034 Read back addr 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, 4-cycle latency.
REQ-035 Completer holds pready=0 for 3 cycles, then returns pslverr=1 -> psel high for 5 cycles in total, and rsp_err=1, rsp_timeout=0.
REQ-036 TIMEOUT_CYCLES=8 with pready tied to 0 -> psel drops after 8 ACCESS cycles, then rsp_timeout=1, rsp_err=1, rsp_rdata=0.
REQ-037 rsp_ready held at 0 for 10 cycles with cmd_valid=1 -> cmd_ready stays 0 and the response stays stable; the next command is accepted the cycle after rsp_ready=1.
REQ-038 preset_n asserted during ACCESS -> psel, penable and rsp_valid go to 0 immediately, and with APB_REQ_STATS_EN defined, stat_xfers=0.
